// File: rtl/ram_sp_arbiter_if.sv
// Requester-side command/response bundle for the two ports of ram_sp_arbiter.
interface ram_sp_arbiter_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/ram_sp_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port 8x256 RAM.
// Read results are steered back to their originator via a latency-matched tag pipe.
module ram_sp_arbiter #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_sp_arbiter_if.slave        bus,
    output logic [7:0]             ram_address,
    output logic [7:0]             ram_data,
    output logic                   ram_wren,
    output logic                   ram_rden,
    input  logic [7:0]             ram_q
);
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned LAST = RD_LAT - 1;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic          last_q, last_d;
    logic          a_gnt_c, b_gnt_c, accept_c;
    logic          sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wren_q, wren_d;
    logic          rden_q, rden_d;
    logic          port_q, port_d;

    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_port_q, tag_port_d;

    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    // Round-robin grant: contention goes to the port that did not win last time.
    always_comb begin
        a_gnt_c = 1'b0;
        b_gnt_c = 1'b0;
        last_d  = last_q;
        if (!rst) begin
            a_gnt_c = bus.a_req && (!bus.b_req || (last_q == PORT_B));
            b_gnt_c = bus.b_req && (!bus.a_req || (last_q == PORT_A));
        end
        if (a_gnt_c) begin
            last_d = PORT_A;
        end else if (b_gnt_c) begin
            last_d = PORT_B;
        end
    end

    assign accept_c = a_gnt_c || b_gnt_c;

    // Issue stage: register the accepted command onto the RAM port.
    always_comb begin
        sel_we_c    = b_gnt_c ? bus.b_we    : bus.a_we;
        sel_addr_c  = b_gnt_c ? bus.b_addr  : bus.a_addr;
        sel_wdata_c = b_gnt_c ? bus.b_wdata : bus.a_wdata;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        rden_d      = 1'b0;
        port_d      = port_q;
        if (accept_c) begin
            addr_d = sel_addr_c;
            wren_d = sel_we_c;
            rden_d = !sel_we_c;
            port_d = b_gnt_c;
            if (sel_we_c) begin
                data_d = sel_wdata_c;
            end
        end
    end

    // Return path: tag pipe tracks each read until q is valid, then registers it out.
    always_comb begin
        tag_vld_d     = '0;
        tag_port_d    = '0;
        tag_vld_d[0]  = rden_q;
        tag_port_d[0] = port_q;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_port_d[k] = tag_port_q[k-1];
        end
        a_rvalid_d = tag_vld_q[LAST] && (tag_port_q[LAST] == PORT_A);
        b_rvalid_d = tag_vld_q[LAST] && (tag_port_q[LAST] == PORT_B);
        a_rdata_d  = a_rvalid_d ? ram_q : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? ram_q : b_rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= PORT_B;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            rden_q     <= 1'b0;
            port_q     <= 1'b0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            rden_q     <= rden_d;
            port_q     <= port_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.a_gnt    = a_gnt_c;
    assign bus.b_gnt    = b_gnt_c;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign ram_address  = addr_q;
    assign ram_data     = data_q;
    assign ram_wren     = wren_q;
    assign ram_rden     = rden_q;
endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: three instances (RD_LAT 2, 1, 4) share one stimulus stream,
// each with its own behavioural RAM; a shared scoreboard predicts every rvalid.
module tb_ram_sp_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

    logic       a_gnt_w [3];
    logic       b_gnt_w [3];
    logic       a_rvalid_w [3];
    logic       b_rvalid_w [3];
    logic [7:0] a_rdata_w [3];
    logic [7:0] b_rdata_w [3];
    logic [7:0] addr_w [3];
    logic [7:0] data_w [3];
    logic       wren_w [3];
    logic       rden_w [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        ram_sp_arbiter_if bus ();
        logic [7:0] ram_address, ram_data, ram_q;
        logic       ram_wren, ram_rden;
        logic [7:0] mem [256];
        logic [7:0] qpipe [LAT];

        assign bus.a_req   = a_req;
        assign bus.a_we    = a_we;
        assign bus.a_addr  = a_addr;
        assign bus.a_wdata = a_wdata;
        assign bus.b_req   = b_req;
        assign bus.b_we    = b_we;
        assign bus.b_addr  = b_addr;
        assign bus.b_wdata = b_wdata;

        ram_sp_arbiter #(.RD_LAT(LAT)) dut (
            .clk        (clk),
            .rst        (rst),
            .bus        (bus),
            .ram_address(ram_address),
            .ram_data   (ram_data),
            .ram_wren   (ram_wren),
            .ram_rden   (ram_rden),
            .ram_q      (ram_q)
        );

        // Single-port RAM with LAT clocks from rden sample to q.
        always @(posedge clk) begin
            if (ram_wren) mem[ram_address] <= ram_data;
            if (ram_rden) qpipe[0] <= mem[ram_address];
            for (int k = 1; k < LAT; k++) qpipe[k] <= qpipe[k-1];
        end
        assign ram_q = qpipe[LAT-1];

        assign a_gnt_w[g]    = bus.a_gnt;
        assign b_gnt_w[g]    = bus.b_gnt;
        assign a_rvalid_w[g] = bus.a_rvalid;
        assign b_rvalid_w[g] = bus.b_rvalid;
        assign a_rdata_w[g]  = bus.a_rdata;
        assign b_rdata_w[g]  = bus.b_rdata;
        assign addr_w[g]     = ram_address;
        assign data_w[g]     = ram_data;
        assign wren_w[g]     = ram_wren;
        assign rden_w[g]     = ram_rden;
    end

    // Scoreboard of predicted read returns.
    typedef struct {
        int         inst;
        logic       port;
        logic [7:0] data;
        int         due;
    } sb_t;
    sb_t        sbq [$];
    logic [7:0] ref_mem [256];
    logic       exp_last = 1'b1;

    // Monitor: arbitration model, scoreboard push on acceptance, pop/compare on rvalid.
    always @(negedge clk) begin
        logic       eg_a, eg_b, we, rv;
        logic [7:0] ad, wd, rd;
        int         idx;
        if (rst) begin
            sbq.delete();
            exp_last = 1'b1;
        end else begin
            eg_a = a_req && (!b_req || exp_last);
            eg_b = b_req && (!a_req || !exp_last);
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (a_gnt_w[i] !== eg_a || b_gnt_w[i] !== eg_b) begin
                    fails++;
                    $display("FAIL grant inst%0d cyc%0d: got a=%b b=%b want a=%b b=%b",
                             i, cyc, a_gnt_w[i], b_gnt_w[i], eg_a, eg_b);
                end
            end
            if (eg_a || eg_b) begin
                we = eg_b ? b_we : a_we;
                ad = eg_b ? b_addr : a_addr;
                wd = eg_b ? b_wdata : a_wdata;
                if (we) begin
                    ref_mem[ad] = wd;
                end else begin
                    for (int i = 0; i < 3; i++)
                        sbq.push_back('{inst: i, port: eg_b, data: ref_mem[ad], due: cyc + 2 + lat_of(i)});
                end
                exp_last = eg_b;
            end
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    rv = (p == 1) ? b_rvalid_w[i] : a_rvalid_w[i];
                    rd = (p == 1) ? b_rdata_w[i] : a_rdata_w[i];
                    if (rv === 1'b1) begin
                        idx = -1;
                        for (int k = 0; k < sbq.size(); k++)
                            if (idx < 0 && sbq[k].inst == i && sbq[k].port == 1'(p)) idx = k;
                        tests++;
                        if (idx < 0) begin
                            fails++;
                            $display("FAIL unexpected_rvalid inst%0d port%0d cyc%0d: got rvalid=1 want 0", i, p, cyc);
                        end else begin
                            if (rd !== sbq[idx].data || cyc != sbq[idx].due) begin
                                fails++;
                                $display("FAIL rdata inst%0d port%0d: got data=%h cyc=%0d want data=%h cyc=%0d",
                                         i, p, rd, cyc, sbq[idx].data, sbq[idx].due);
                            end
                            sbq.delete(idx);
                        end
                    end
                end
            end
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].due < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_rvalid inst%0d port%0d: got none by cyc%0d want at cyc%0d",
                             sbq[k].inst, sbq[k].port, cyc, sbq[k].due);
                    sbq.delete(k);
                end
            end
        end
    end

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;
    cmd_t cmd_a [$];
    cmd_t cmd_b [$];
    logic gnt_log [$];
    int   first_gnt_cyc;

    function automatic cmd_t mk(input logic we, input int addr, input int wdata);
        cmd_t c;
        c.we = we;
        c.addr = 8'(addr);
        c.wdata = 8'(wdata);
        return c;
    endfunction

    // Play both command queues through the handshake, recording grant order.
    task automatic run_cmds(input int budget, output int used);
        logic ga, gb;
        used = 0;
        first_gnt_cyc = -1;
        gnt_log.delete();
        while ((cmd_a.size() > 0 || cmd_b.size() > 0) && used < budget) begin
            a_req = (cmd_a.size() > 0);
            b_req = (cmd_b.size() > 0);
            if (a_req) begin a_we = cmd_a[0].we; a_addr = cmd_a[0].addr; a_wdata = cmd_a[0].wdata; end
            if (b_req) begin b_we = cmd_b[0].we; b_addr = cmd_b[0].addr; b_wdata = cmd_b[0].wdata; end
            @(negedge clk);
            ga = a_gnt_w[0] && a_req;
            gb = b_gnt_w[0] && b_req;
            if ((ga || gb) && first_gnt_cyc < 0) first_gnt_cyc = cyc;
            if (ga) gnt_log.push_back(1'b0);
            if (gb) gnt_log.push_back(1'b1);
            @(posedge clk); #1;
            if (ga) void'(cmd_a.pop_front());
            if (gb) void'(cmd_b.pop_front());
            used++;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tests++;
        if (cmd_a.size() > 0 || cmd_b.size() > 0) begin
            fails++;
            $display("FAIL cmd_timeout: got %0d/%0d commands left want 0", cmd_a.size(), cmd_b.size());
            cmd_a.delete();
            cmd_b.delete();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (sbq.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending reads want 0", sbq.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (addr_w[i] !== 8'h00 || data_w[i] !== 8'h00 || wren_w[i] !== 1'b0 || rden_w[i] !== 1'b0 ||
                a_rvalid_w[i] !== 1'b0 || b_rvalid_w[i] !== 1'b0 || a_rdata_w[i] !== 8'h00 || b_rdata_w[i] !== 8'h00) begin
                fails++;
                $display("FAIL %s inst%0d: got addr=%h data=%h wr=%b rd=%b av=%b bv=%b ad=%h bd=%h want all 0",
                         tag, i, addr_w[i], data_w[i], wren_w[i], rden_w[i], a_rvalid_w[i], b_rvalid_w[i],
                         a_rdata_w[i], b_rdata_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01; a_wdata = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02; b_wdata = 8'h00;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (a_gnt_w[i] !== 1'b0 || b_gnt_w[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL gnt_in_reset inst%0d: got a=%b b=%b want 0 0", i, a_gnt_w[i], b_gnt_w[i]);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_values");
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'hA5;
        @(negedge clk);
        tests++;
        if (a_gnt_w[0] !== 1'b1) begin fails++; $display("FAIL wr_gnt: got %b want 1", a_gnt_w[0]); end
        @(posedge clk); #1;
        a_we = 1'b0;
        @(negedge clk);
        tests++;
        if (a_gnt_w[0] !== 1'b1) begin fails++; $display("FAIL rd_gnt: got %b want 1", a_gnt_w[0]); end
        tests++;
        if (wren_w[0] !== 1'b1 || rden_w[0] !== 1'b0 || addr_w[0] !== 8'h10 || data_w[0] !== 8'hA5) begin
            fails++;
            $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h want 1 0 10 a5",
                     wren_w[0], rden_w[0], addr_w[0], data_w[0]);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        tests++;
        if (wren_w[0] !== 1'b0 || rden_w[0] !== 1'b1 || addr_w[0] !== 8'h10 || data_w[0] !== 8'hA5) begin
            fails++;
            $display("FAIL rd_issue: got wr=%b rd=%b addr=%h data=%h want 0 1 10 a5",
                     wren_w[0], rden_w[0], addr_w[0], data_w[0]);
        end
        for (int t = 3; t <= 5; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            tests++;
            if (a_rvalid_w[0] !== (t == 5) || b_rvalid_w[0] !== 1'b0 || (t == 3 && (wren_w[0] | rden_w[0]) !== 1'b0)) begin
                fails++;
                $display("FAIL wr_rd_timing T+%0d: got av=%b bv=%b wr=%b rd=%b want av=%b bv=0",
                         t, a_rvalid_w[0], b_rvalid_w[0], wren_w[0], rden_w[0], (t == 5));
            end
            if (t == 5) begin
                tests++;
                if (a_rdata_w[0] !== 8'hA5) begin
                    fails++;
                    $display("FAIL wr_rd_data: got %h want a5", a_rdata_w[0]);
                end
            end
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_contention();
        int used;
        for (int k = 10; k <= 20; k++) cmd_a.push_back(mk(1'b1, k, k));
        run_cmds(20, used);
        for (int k = 30; k <= 40; k++) cmd_b.push_back(mk(1'b1, k, k));
        run_cmds(20, used);
        do_reset();
        for (int k = 10; k <= 20; k++) cmd_a.push_back(mk(1'b0, k, 0));
        for (int k = 30; k <= 40; k++) cmd_b.push_back(mk(1'b0, k, 0));
        run_cmds(40, used);
        tests++;
        if (gnt_log.size() != 22 || used != 22) begin
            fails++;
            $display("FAIL contention_count: got grants=%0d cycles=%0d want 22 22", gnt_log.size(), used);
        end
        for (int k = 0; k < gnt_log.size(); k++) begin
            tests++;
            if (gnt_log[k] !== 1'(k % 2)) begin
                fails++;
                $display("FAIL alternate[%0d]: got port %b want %b", k, gnt_log[k], 1'(k % 2));
            end
        end
        drain();
    endtask

    task automatic test_same_cycle();
        int used;
        cmd_a.push_back(mk(1'b0, 12, 0));
        run_cmds(5, used);
        cmd_b.push_back(mk(1'b1, 8'hFF, 8'h3C));
        cmd_a.push_back(mk(1'b0, 8'hFF, 0));
        run_cmds(5, used);
        tests++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 1'b1 || gnt_log[1] !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_order: got n=%0d first=%b want n=2 B then A", gnt_log.size(),
                     (gnt_log.size() > 0) ? gnt_log[0] : 1'bx);
        end
        drain();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (a_rdata_w[i] !== 8'h3C) begin
                fails++;
                $display("FAIL same_cycle_data inst%0d: got %h want 3c", i, a_rdata_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int used;
        for (int k = 10; k < 18; k++) cmd_a.push_back(mk(1'b0, k, 0));
        run_cmds(16, used);
        tests++;
        if (used != 8 || gnt_log.size() != 8) begin
            fails++;
            $display("FAIL back_to_back: got cycles=%0d grants=%0d want 8 8", used, gnt_log.size());
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        int used;
        int seen = 0;
        cmd_a.push_back(mk(1'b0, 10, 0));
        cmd_a.push_back(mk(1'b0, 11, 0));
        run_cmds(5, used);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");
        repeat (8) begin
            @(posedge clk); #1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) seen += int'(a_rvalid_w[i] === 1'b1) + int'(b_rvalid_w[i] === 1'b1);
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL dropped_reads: got %0d rvalid pulses want 0", seen);
        end
        @(posedge clk); #1;
        cmd_a.push_back(mk(1'b0, 12, 0));
        cmd_b.push_back(mk(1'b0, 31, 0));
        run_cmds(5, used);
        tests++;
        if (gnt_log.size() < 1 || gnt_log[0] !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_first: got %0d grants, first=%b want A", gnt_log.size(),
                     (gnt_log.size() > 0) ? gnt_log[0] : 1'bx);
        end
        drain();
    endtask

    task automatic test_latency();
        int used;
        int seen [3];
        for (int i = 0; i < 3; i++) seen[i] = -1;
        cmd_a.push_back(mk(1'b0, 20, 0));
        run_cmds(5, used);
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (a_rvalid_w[i] === 1'b1 && seen[i] < 0) seen[i] = cyc - first_gnt_cyc;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (seen[i] != lat_of(i) + 2) begin
                fails++;
                $display("FAIL latency RD_LAT=%0d: got %0d cycles want %0d", lat_of(i), seen[i], lat_of(i) + 2);
            end
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        test_reset();
        test_write_read();
        test_contention();
        test_same_cycle();
        test_back_to_back();
        test_reset_inflight();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000 want finish");
        $fatal(1, "timeout");
    end
endmodule
